// File: rtl/tone_gen.sv
// tone_gen: note code + octave shift -> square wave.
// A 4-bit note selects a base half-period, right-shifted by the octave.
// A prescaler divides clk into ticks, and a half counter then toggles
// tone_out every (period_out+1)*PRESCALE clk cycles.
// While a tone is playing, note changes wait in a pending register and
// take effect only at a half-period boundary, so the output never glitches.
// Optional macro TONE_NOTE_ACK_EN adds a one-clk note_ack pulse on every
// period_out update.
module tone_gen #(
  parameter int CNT_W    = 11,
  parameter int OCT_W    = 2,
  parameter int PRESCALE = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             note_vld,
  input  logic [3:0]       note,
  input  logic [OCT_W-1:0] oct,
`ifdef TONE_NOTE_ACK_EN
  output logic             note_ack,
`endif
  output logic             tone_out,
  output logic [CNT_W-1:0] period_out
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  // Base half-period table, in prescaler ticks minus one.
  function automatic logic [10:0] base_tab(input logic [3:0] n);
    case (n)
      4'd0:  return 11'd1666;
      4'd1:  return 11'd999;
      4'd2:  return 11'd666;
      4'd3:  return 11'd499;
      4'd4:  return 11'd399;
      4'd5:  return 11'd332;
      4'd6:  return 11'd285;
      4'd7:  return 11'd249;
      4'd8:  return 11'd221;
      4'd9:  return 11'd199;
      4'd10: return 11'd181;
      4'd11: return 11'd165;
      4'd12: return 11'd152;
      4'd13: return 11'd141;
      4'd14: return 11'd132;
      default: return 11'd124;
    endcase
  endfunction

  logic [PS_W-1:0]  r_pcnt;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_pend_period;
  logic             r_pend;
  logic             r_tone;
  logic [CNT_W-1:0] r_period;
  logic             r_ack;

  logic [CNT_W-1:0] w_base;
  logic [CNT_W-1:0] w_shift;
  logic [CNT_W-1:0] w_new;
  logic             w_idle;
  logic             w_run;
  logic             w_tick;
  logic             w_bnd;

  // The cast truncates narrow builds to the low CNT_W bits before the
  // shift. A zero result is clamped to 1 so a loaded note never looks idle.
  assign w_base  = CNT_W'(base_tab(note));
  assign w_shift = w_base >> oct;
  assign w_new   = (w_shift == '0) ? CNT_W'(1) : w_shift;

  assign w_idle  = (r_period == '0);
  assign w_run   = en && !w_idle;
  assign w_tick  = w_run && (r_pcnt == PS_W'(PRESCALE - 1));
  assign w_bnd   = w_tick && (r_hcnt == r_period);

  // Prescaler: free-runs only while enabled and a note is loaded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                r_pcnt <= '0;
    else if (!w_run||w_tick) r_pcnt <= '0;
    else                     r_pcnt <= r_pcnt + 1'b1;
  end

  // Half counter and output toggle; mute or idle forces both low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hcnt <= '0;
      r_tone <= 1'b0;
    end else if (!w_run) begin
      r_hcnt <= '0;
      r_tone <= 1'b0;
    end else if (w_bnd) begin
      r_hcnt <= '0;
      r_tone <= ~r_tone;
    end else if (w_tick) begin
      r_hcnt <= r_hcnt + 1'b1;
    end
  end

  // Period update: loads directly when idle, otherwise only at a boundary.
  // A strobe landing on the boundary itself beats any pending value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_period      <= '0;
      r_pend_period <= '0;
      r_pend        <= 1'b0;
      r_ack         <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      if (w_idle) begin
        if (note_vld) begin
          r_period <= w_new;
          r_pend   <= 1'b0;
          r_ack    <= 1'b1;
        end
      end else if (w_bnd && note_vld) begin
        r_period <= w_new;
        r_pend   <= 1'b0;
        r_ack    <= 1'b1;
      end else if (w_bnd && r_pend) begin
        r_period <= r_pend_period;
        r_pend   <= 1'b0;
        r_ack    <= 1'b1;
      end else if (note_vld) begin
        r_pend_period <= w_new;
        r_pend        <= 1'b1;
      end
    end
  end

  assign tone_out   = r_tone;
  assign period_out = r_period;

`ifdef TONE_NOTE_ACK_EN
  assign note_ack = r_ack;
`else
  logic w_ack_unused;
  assign w_ack_unused = r_ack;
`endif

endmodule
